// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK link test chain: aligner defaults and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default window/threshold/counter width and the aligner state type.
package qpsk_pkg;

  localparam int DELAY_LEN_DEF = 512;  // one PRBS9 period of candidate latencies
  localparam int WINDOW_DEF    = 511;  // enabled bits per evaluation window
  localparam int LOSS_THR_DEF  = 64;   // window errors at/above which lock is dropped
  localparam int CNT_W_DEF     = 64;   // bit/error counter width

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clear has priority over inc.
// Latency: count updates on the edge after inc/clear.
// Backpressure: none; inc is simply ignored once saturated.
// Ports: CLK100MHZ/reset (sync, active-high), inc, clear, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK100MHZ,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK100MHZ) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ber_aligner.sv
// PRBS9 BER aligner: sweeps reference delays for a zero-error (or best) window, then counts bits/errors.
// Latency: lock/loss decisions and o_err are registered, visible the cycle after the deciding enable.
// Backpressure: none; all state advances only on enable strobes, idle cycles freeze everything.
// Ports: CLK100MHZ, reset (sync, active-high), enable, i_prbs, i_rx, i_clear ->
//        o_locked, o_latency, o_bit_count, o_err_count, o_err.
module ber_aligner
  import qpsk_pkg::*;
#(
  parameter int DELAY_LEN = DELAY_LEN_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  parameter int LOSS_THR  = LOSS_THR_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                         CLK100MHZ,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         i_prbs,
  input  logic                         i_rx,
  input  logic                         i_clear,
  output logic                         o_locked,
  output logic [$clog2(DELAY_LEN)-1:0] o_latency,
  output logic [CNT_W-1:0]             o_bit_count,
  output logic [CNT_W-1:0]             o_err_count,
  output logic                         o_err
);

  localparam int          LAT_W      = $clog2(DELAY_LEN);
  localparam int          WC_W       = $clog2(WINDOW + 1);
  localparam logic [31:0] LOSS_THR_U = 32'(LOSS_THR);

  align_state_t     state, state_nxt;
  logic [LAT_W-1:0] cand, cand_nxt;
  logic [LAT_W-1:0] best, best_nxt;
  logic [LAT_W-1:0] lat_nxt;
  logic [WC_W-1:0]  min_err, min_nxt;

  logic [DELAY_LEN-2:0] dl;
  logic [DELAY_LEN-1:0] ref_vec;
  logic [LAT_W-1:0]     k_sel;
  logic                 err_bit;
  logic [WC_W-1:0]      win_cnt;
  logic [WC_W-1:0]      win_err;
  logic [WC_W-1:0]      tot;
  logic                 win_end;
  logic                 better;

  // ref_vec[k] is i_prbs delayed k enables; index 0 is the live input bit.
  assign ref_vec = {dl, i_prbs};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      dl <= '0;
    end else if (enable) begin
      dl <= ref_vec[DELAY_LEN-2:0];
    end
  end

  assign o_locked = (state == LOCKED);
  assign k_sel    = o_locked ? o_latency : cand;
  assign err_bit  = i_rx ^ ref_vec[k_sel];
  assign win_end  = enable && (win_cnt == WC_W'(WINDOW - 1));
  // Window total includes the bit being compared on the closing enable.
  assign tot      = win_err + {{(WC_W-1){1'b0}}, err_bit};
  assign better   = (tot < min_err);

  // The same window counters serve the search sweep and the loss monitor;
  // every state change happens on a window end, which also restarts them.
  sat_counter #(.W(WC_W)) u_win_cnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .inc       (enable),
    .clear     (win_end),
    .count     (win_cnt)
  );

  sat_counter #(.W(WC_W)) u_win_err (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .inc       (enable && err_bit),
    .clear     (win_end),
    .count     (win_err)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .inc       (enable && o_locked),
    .clear     (i_clear),
    .count     (o_bit_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .inc       (enable && o_locked && err_bit),
    .clear     (i_clear),
    .count     (o_err_count)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state     <= SEARCH;
      cand      <= '0;
      best      <= '0;
      min_err   <= '1;
      o_latency <= '0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      best      <= best_nxt;
      min_err   <= min_nxt;
      o_latency <= lat_nxt;
      o_err     <= enable && o_locked && err_bit;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    best_nxt  = best;
    min_nxt   = min_err;
    lat_nxt   = o_latency;
    if (win_end) begin
      if (state == SEARCH) begin
        if (tot == '0) begin
          state_nxt = LOCKED;
          lat_nxt   = cand;
        end else begin
          // Strict compare: on a tie the earlier candidate stays best.
          if (better) begin
            min_nxt  = tot;
            best_nxt = cand;
          end
          if (cand == LAT_W'(DELAY_LEN - 1)) begin
            state_nxt = LOCKED;
            lat_nxt   = better ? cand : best;
          end else begin
            cand_nxt = cand + 1'b1;
          end
        end
      end else begin
        if (32'(tot) >= LOSS_THR_U) begin
          state_nxt = SEARCH;
          cand_nxt  = '0;
          best_nxt  = '0;
          min_nxt   = '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ber_aligner.sv
// Testbench for ber_aligner: two instances (32-bit counters / loss threshold 8, and 8-bit counters).
// Latency: stimulus is one enable every four clocks; outputs are sampled 1 time unit after edges.
// Backpressure: n/a.
module tb_ber_aligner;

  logic        CLK100MHZ, reset, enable, i_prbs, rx_a, rx_b, clr_a, clr_b;
  logic        locked_a, err_a, locked_b, err_b;
  logic [3:0]  lat_a, lat_b;
  logic [31:0] bits_a, errs_a;
  logic [7:0]  bits_b, errs_b;

  ber_aligner #(.DELAY_LEN(16), .WINDOW(31), .LOSS_THR(8), .CNT_W(32)) dut_a (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .enable(enable), .i_prbs(i_prbs), .i_rx(rx_a),
    .i_clear(clr_a), .o_locked(locked_a), .o_latency(lat_a), .o_bit_count(bits_a),
    .o_err_count(errs_a), .o_err(err_a));

  ber_aligner #(.DELAY_LEN(16), .WINDOW(31), .LOSS_THR(64), .CNT_W(8)) dut_b (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .enable(enable), .i_prbs(i_prbs), .i_rx(rx_b),
    .i_clear(clr_b), .o_locked(locked_b), .o_latency(lat_b), .o_bit_count(bits_b),
    .o_err_count(errs_b), .o_err(err_b));

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  logic [8:0]  lfsr;
  logic        cur;         // PRBS bit presented on the next enable
  logic [31:0] hist;        // hist[j] = PRBS bit j+1 enables ago
  logic        err_seen_a, err_seen_b;
  logic        exp_q[$];    // scoreboard of expected o_err pulses
  int          n_checks, n_fail;
  int          exp_bits, exp_errs, mon_pos, mon_errs;

  function automatic logic tap(input int k);
    if (k == 0) return cur;
    return hist[k-1];
  endfunction

  // One symbol: an enable cycle followed by three idle cycles.
  task automatic sym(input logic ra, input logic rb, input logic ca, input logic cb, input logic rst);
    enable = 1'b1; i_prbs = cur; rx_a = ra; rx_b = rb; clr_a = ca; clr_b = cb; reset = rst;
    @(posedge CLK100MHZ); #1;
    err_seen_a = err_a; err_seen_b = err_b;
    hist = rst ? 32'd0 : {hist[30:0], cur};
    cur = lfsr[8];
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    enable = 1'b0; clr_a = 1'b0; clr_b = 1'b0; reset = 1'b0;
    repeat (3) begin @(posedge CLK100MHZ); #1; end
  endtask

  // Locked-phase symbol for dut_a: queues the expected pulse and predicts loss of lock.
  task automatic lsym(input logic ra, input int lat, output logic exp_lock);
    logic e;
    e = ra ^ tap(lat);
    exp_q.push_back(e);
    exp_bits++;
    if (e) begin exp_errs++; mon_errs++; end
    mon_pos++;
    exp_lock = 1'b1;
    if (mon_pos == 31) begin
      if (mon_errs >= 8) exp_lock = 1'b0;
      mon_pos = 0; mon_errs = 0;
    end
    sym(ra, tap(lat), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (2) @(posedge CLK100MHZ); #1;
    reset = 1'b0; hist = '0;
    exp_bits = 0; exp_errs = 0; mon_pos = 0; mon_errs = 0; exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clr_a = 1'b1; clr_b = 1'b1; i_prbs = 1'b1; rx_a = 1'b0; rx_b = 1'b0;
    repeat (2) @(posedge CLK100MHZ); #1;
    n_checks++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset_locked_a: got %0d, expected 0", locked_a); end
    n_checks++; if (lat_a !== 4'd0) begin n_fail++; $display("FAIL reset_lat_a: got %0d, expected 0", lat_a); end
    n_checks++; if (bits_a !== 32'd0) begin n_fail++; $display("FAIL reset_bits_a: got %0d, expected 0", bits_a); end
    n_checks++; if (errs_a !== 32'd0) begin n_fail++; $display("FAIL reset_errs_a: got %0d, expected 0", errs_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %0d, expected 0", err_a); end
    n_checks++; if (locked_b !== 1'b0) begin n_fail++; $display("FAIL reset_locked_b: got %0d, expected 0", locked_b); end
    n_checks++; if (bits_b !== 8'd0) begin n_fail++; $display("FAIL reset_bits_b: got %0d, expected 0", bits_b); end
    reset = 1'b0; enable = 1'b0; clr_a = 1'b0; clr_b = 1'b0; hist = '0;
    exp_bits = 0; exp_errs = 0; mon_pos = 0; mon_errs = 0;
  endtask

  // Search sweep on dut_a: must lock exactly on enable n, never pulse o_err, counters held.
  task automatic test_search_lock(input int lat_rx, input int n, input int period, input int exp_lat, input string name);
    logic r;
    for (int i = 1; i <= n; i++) begin
      r = tap(lat_rx);
      if (period != 0 && (i % period) == period - 1) r = ~r;
      sym(r, tap(lat_rx), 1'b0, 1'b0, 1'b0);
      n_checks++; if (err_seen_a !== 1'b0) begin n_fail++; $display("FAIL %s_search_err: enable %0d got %0d, expected 0", name, i, err_seen_a); end
      n_checks++; if (locked_a !== (i == n)) begin n_fail++; $display("FAIL %s_lock_time: enable %0d got %0d, expected %0d", name, i, locked_a, (i == n)); end
    end
    n_checks++; if (lat_a !== 4'(exp_lat)) begin n_fail++; $display("FAIL %s_latency: got %0d, expected %0d", name, lat_a, exp_lat); end
    n_checks++; if (bits_a !== 32'(exp_bits)) begin n_fail++; $display("FAIL %s_bits_held: got %0d, expected %0d", name, bits_a, exp_bits); end
    n_checks++; if (errs_a !== 32'(exp_errs)) begin n_fail++; $display("FAIL %s_errs_held: got %0d, expected %0d", name, errs_a, exp_errs); end
    mon_pos = 0; mon_errs = 0;
  endtask

  task automatic test_single_error();
    logic r, el, e;
    for (int i = 0; i < 41; i++) begin
      r = tap(7);
      if (i == 20) r = ~r;
      lsym(r, 7, el);
      e = exp_q.pop_front();
      n_checks++; if (err_seen_a !== e) begin n_fail++; $display("FAIL single_err_pulse: bit %0d got %0d, expected %0d", i, err_seen_a, e); end
      n_checks++; if (locked_a !== el) begin n_fail++; $display("FAIL single_err_locked: bit %0d got %0d, expected %0d", i, locked_a, el); end
    end
    n_checks++; if (errs_a !== 32'(exp_errs)) begin n_fail++; $display("FAIL single_err_count: got %0d, expected %0d", errs_a, exp_errs); end
    n_checks++; if (bits_a !== 32'(exp_bits)) begin n_fail++; $display("FAIL single_bit_count: got %0d, expected %0d", bits_a, exp_bits); end
  endtask

  task automatic test_loss();
    logic el, e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 70 && !seen; i++) begin
      lsym(1'b0, 7, el);
      e = exp_q.pop_front();
      n_checks++; if (err_seen_a !== e) begin n_fail++; $display("FAIL loss_err_pulse: bit %0d got %0d, expected %0d", i, err_seen_a, e); end
      n_checks++; if (locked_a !== el) begin n_fail++; $display("FAIL loss_locked: bit %0d got %0d, expected %0d", i, locked_a, el); end
      if (!el) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL loss_timeout: got 0 losses, expected 1"); end
    n_checks++; if (bits_a !== 32'(exp_bits)) begin n_fail++; $display("FAIL loss_bits_hold: got %0d, expected %0d", bits_a, exp_bits); end
    n_checks++; if (errs_a !== 32'(exp_errs)) begin n_fail++; $display("FAIL loss_errs_hold: got %0d, expected %0d", errs_a, exp_errs); end
  endtask

  task automatic test_reset_mid_search();
    logic el, e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      lsym(~tap(3), 3, el);
      e = exp_q.pop_front();
      n_checks++; if (err_seen_a !== e) begin n_fail++; $display("FAIL inv_err_pulse: bit %0d got %0d, expected %0d", i, err_seen_a, e); end
      n_checks++; if (locked_a !== el) begin n_fail++; $display("FAIL inv_locked: bit %0d got %0d, expected %0d", i, locked_a, el); end
      if (!el) seen = 1'b1;
    end
    // Now searching again; walk into the middle of candidate 5.
    for (int i = 0; i < 5 * 31 + 10; i++) sym(tap(7), tap(7), 1'b0, 1'b0, 1'b0);
    n_checks++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL mid_search_locked: got %0d, expected 0", locked_a); end
    n_checks++; if (bits_a !== 32'(exp_bits)) begin n_fail++; $display("FAIL mid_search_bits: got %0d, expected %0d", bits_a, exp_bits); end
    // Reset with enable and clear also high.
    sym(tap(7), tap(7), 1'b1, 1'b1, 1'b1);
    n_checks++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0d, expected 0", locked_a); end
    n_checks++; if (lat_a !== 4'd0) begin n_fail++; $display("FAIL rst_latency: got %0d, expected 0", lat_a); end
    n_checks++; if (bits_a !== 32'd0) begin n_fail++; $display("FAIL rst_bits: got %0d, expected 0", bits_a); end
    n_checks++; if (errs_a !== 32'd0) begin n_fail++; $display("FAIL rst_errs: got %0d, expected 0", errs_a); end
    n_checks++; if (err_seen_a !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0d, expected 0", err_seen_a); end
    exp_bits = 0; exp_errs = 0; mon_pos = 0; mon_errs = 0; exp_q.delete();
  endtask

  task automatic test_saturate();
    logic e;
    n_checks++; if (locked_b !== 1'b1) begin n_fail++; $display("FAIL sat_locked_b: got %0d, expected 1", locked_b); end
    n_checks++; if (lat_b !== 4'd7) begin n_fail++; $display("FAIL sat_latency_b: got %0d, expected 7", lat_b); end
    for (int i = 1; i <= 260; i++) begin
      exp_q.push_back(1'b1);
      sym(tap(7), ~tap(7), 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++; if (err_seen_b !== e) begin n_fail++; $display("FAIL sat_err_pulse: bit %0d got %0d, expected %0d", i, err_seen_b, e); end
      if (i == 255) begin
        n_checks++; if (errs_b !== 8'd255) begin n_fail++; $display("FAIL sat_errs_255: got %0d, expected 255", errs_b); end
      end
    end
    n_checks++; if (errs_b !== 8'd255) begin n_fail++; $display("FAIL sat_errs_hold: got %0d, expected 255", errs_b); end
    n_checks++; if (bits_b !== 8'd255) begin n_fail++; $display("FAIL sat_bits_hold: got %0d, expected 255", bits_b); end
    n_checks++; if (locked_b !== 1'b1) begin n_fail++; $display("FAIL sat_still_locked: got %0d, expected 1", locked_b); end
    exp_q.push_back(1'b1);
    sym(tap(7), ~tap(7), 1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (err_seen_b !== e) begin n_fail++; $display("FAIL clr_err_pulse: got %0d, expected %0d", err_seen_b, e); end
    n_checks++; if (errs_b !== 8'd0) begin n_fail++; $display("FAIL clr_errs: got %0d, expected 0", errs_b); end
    n_checks++; if (bits_b !== 8'd0) begin n_fail++; $display("FAIL clr_bits: got %0d, expected 0", bits_b); end
    sym(tap(7), ~tap(7), 1'b0, 1'b0, 1'b0);
    n_checks++; if (errs_b !== 8'd1) begin n_fail++; $display("FAIL post_clr_errs: got %0d, expected 1", errs_b); end
    n_checks++; if (bits_b !== 8'd1) begin n_fail++; $display("FAIL post_clr_bits: got %0d, expected 1", bits_b); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    lfsr = 9'h1FF;
    cur = lfsr[8];
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    hist = '0;
    reset = 1'b1; enable = 1'b0; i_prbs = 1'b0; rx_a = 1'b0; rx_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    err_seen_a = 1'b0; err_seen_b = 1'b0;
    test_reset();
    test_search_lock(7, 248, 0, 7, "lock_lat7");
    test_single_error();
    test_loss();
    test_search_lock(7, 248, 0, 7, "relock_lat7");
    do_reset();
    test_search_lock(3, 496, 10, 3, "noisy_lat3");
    test_reset_mid_search();
    test_search_lock(7, 248, 0, 7, "restart_lat7");
    do_reset();
    test_search_lock(7, 248, 0, 7, "lock_b");
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_aligner.md
BER_ALIGNER -- requirements
Module: ber_aligner

Interface
REQ-001 Parameter DELAY_LEN, default 512: number of candidate latencies (0..DELAY_LEN-1), covers one PRBS9 period.
REQ-002 Parameter WINDOW, default 511: enabled bits per evaluation window.
REQ-003 Parameter LOSS_THR, default 64: window error count at or above which lock is lost.
REQ-004 Parameter CNT_W, default 64: width of bit/error counters.
REQ-005 CLK100MHZ  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  symbol strobe (one cycle in four); all state advances only when high.
REQ-008 i_prbs  input  1  reference PRBS9 bit from the generator.
REQ-009 i_rx  input  1  recovered bit from the receiver.
REQ-010 i_clear  input  1  one-cycle pulse; zeroes o_bit_count and o_err_count only.
REQ-011 o_locked  output  1  high in LOCKED state.
REQ-012 o_latency  output  clog2(DELAY_LEN)  selected reference delay in enabled bits.
REQ-013 o_bit_count  output  CNT_W  bits compared while locked.
REQ-014 o_err_count  output  CNT_W  mismatches while locked.
REQ-015 o_err  output  1  one-cycle pulse on each locked mismatch, registered.

Function
REQ-016 Reference delay line SHALL shift i_prbs in on every enable; ref(k) = i_prbs delayed k enables, ref(0) = current i_prbs.
REQ-017 Comparison SHALL be err = i_rx XOR ref(k), k = candidate (SEARCH) or o_latency (LOCKED), evaluated only when enable is high.
REQ-018 FSM states SHALL be SEARCH and LOCKED; reset enters SEARCH with k=0, window counter 0, min_err all-ones, best=0.
REQ-019 In SEARCH each candidate SHALL be evaluated over exactly WINDOW enabled bits, accumulating window errors.
REQ-020 At window end with zero errors, FSM SHALL go to LOCKED next cycle with o_latency=k.
REQ-021 At window end with errors < min_err (strict), min_err and best SHALL update; ties keep the earlier candidate.
REQ-022 After window end k SHALL increment; on window end of k=DELAY_LEN-1 with no zero-error candidate, FSM SHALL lock with o_latency=best.
REQ-023 In LOCKED, each enable SHALL increment o_bit_count and, on mismatch, o_err_count and pulse o_err.
REQ-024 Counters SHALL saturate at all-ones, never wrap.
REQ-025 In LOCKED, a WINDOW-bit loss monitor SHALL run; window errors >= LOSS_THR SHALL return FSM to SEARCH next cycle with k=0, min_err all-ones; counters hold.
REQ-026 i_clear coincident with an increment SHALL win (counter reads 0 next cycle).
REQ-027 enable low SHALL freeze delay line, FSM, window counters and all counts.
REQ-028 o_err SHALL be 0 while in SEARCH.

Reset
REQ-029 reset SHALL clear delay line, counters, o_latency, o_locked, o_err to 0 in the same edge, overriding enable and i_clear, including mid-search or mid-lock.

Structure
REQ-030 WINDOW/LOSS_THR defaults, state encoding and counter width SHALL live in the shared qpsk package.
REQ-031 One sub-module, sat_counter (parameterised width, inc, clear, saturate), SHALL implement o_bit_count, o_err_count and the window counters.

Verification
REQ-032 DELAY_LEN=16, WINDOW=31, i_rx = i_prbs delayed 7 enables -> o_locked rises after 8 windows (248 enables), o_latency=7, o_err_count stays 0.
REQ-033 Locked at latency 7, flip one i_rx bit -> single o_err pulse, o_err_count=1, o_bit_count keeps counting.
REQ-034 Locked, force i_rx=0 -> within one window o_locked falls, search restarts at k=0 and relocks at 7 once i_rx restored.
REQ-035 i_rx delayed 3 with one error every 10 bits -> no zero candidate; full sweep, lock at o_latency=3.
REQ-036 CNT_W=8, locked with i_rx = ~ref -> o_err_count stops at 255; i_clear -> both counts 0 next cycle.
REQ-037 reset pulsed mid-search at k=5 -> all outputs 0 next cycle, sweep restarts at k=0.
